uart_mode1_ctrl: RTL

- Serial-port controller that sequences the mode-1 UART RX and TX engines of the 8051 core.
- Owns the SCON and SBUF SFRs and generates the shared tick_baud from Timer-1 overflow, divided per PCON.SMOD.
- Gates the RX engine with REN, launches TX transfers, and maintains RI/TI/RB8 plus the serial interrupt.
- Sits between the SFR bus and the uart rx/tx datapaths.

---
 rtl/uart_mode1_ctrl_pkg.sv | 38 +++
 rtl/uart_mode1_ctrl_if.sv | 18 +
 rtl/uart_mode1_ctrl_baud_gen.sv | 43 ++++
 rtl/uart_mode1_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/uart_mode1_ctrl_pkg.sv
// Shared constants for the 8051 serial-port controller: SFR addresses, SCON bit map,
// mode and TX state encodings, baud divisor defaults.
package uart_8051_pkg;

  localparam logic [7:0] SCON_ADDR_DEF = 8'h98;
  localparam logic [7:0] SBUF_ADDR_DEF = 8'h99;

  localparam int DIV_SMOD0_DEF = 32;
  localparam int DIV_SMOD1_DEF = 16;

  localparam int SCON_SM0 = 7;
  localparam int SCON_SM1 = 6;
  localparam int SCON_SM2 = 5;
  localparam int SCON_REN = 4;
  localparam int SCON_TB8 = 3;
  localparam int SCON_RB8 = 2;
  localparam int SCON_TI  = 1;
  localparam int SCON_RI  = 0;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } uart_mode_e;

  typedef enum logic [1:0] {
    TX_IDLE = 2'b00,
    TX_LOAD = 2'b01,
    TX_BUSY = 2'b10
  } tx_state_e;

  // Prescaler terminal count; divisors are bounded to 2..32 so the result fits 5 bits.
  function automatic logic [4:0] baud_term(input logic smod, input int div0, input int div1);
    return smod ? 5'(div1 - 1) : 5'(div0 - 1);
  endfunction

endpackage

// File: rtl/uart_mode1_ctrl_if.sv
// SFR bus between the CPU core (master) and the serial-port controller (slave).
interface uart_mode1_ctrl_if;
  logic [7:0] sfr_addr;
  logic       sfr_wr;
  logic       sfr_rd;
  logic [7:0] sfr_wdata;
  logic [7:0] sfr_rdata;

  modport master (
    output sfr_addr, sfr_wr, sfr_rd, sfr_wdata,
    input  sfr_rdata
  );

  modport slave (
    input  sfr_addr, sfr_wr, sfr_rd, sfr_wdata,
    output sfr_rdata
  );
endinterface

// File: rtl/uart_mode1_ctrl_baud_gen.sv
// Baud prescaler: divides Timer-1 overflow pulses into a one-clk tick_baud.
// Held at zero while en is low so a mode change restarts a clean count.
module uart_baud_gen
  import uart_8051_pkg::*;
#(
  parameter int DIV_SMOD0 = DIV_SMOD0_DEF,
  parameter int DIV_SMOD1 = DIV_SMOD1_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic smod,
  input  logic t1_ovf,
  output logic tick_baud
);

  logic [4:0] cnt;
  logic [4:0] term;

  assign term = baud_term(smod, DIV_SMOD0, DIV_SMOD1);

  // >= rather than == so an smod switch to a shorter divisor cannot run past the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      tick_baud <= 1'b0;
    end else if (!en) begin
      cnt       <= '0;
      tick_baud <= 1'b0;
    end else begin
      tick_baud <= 1'b0;
      if (t1_ovf) begin
        if (cnt >= term) begin
          cnt       <= '0;
          tick_baud <= 1'b1;
        end else begin
          cnt <= cnt + 5'd1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_mode1_ctrl.sv
// Mode-1 serial-port controller: SCON/SBUF SFRs, baud tick, RX gating, TX launch, serial irq.
// Optional macro UART_OVR_FLAG_EN adds a sticky receive-overrun output (ovr).
//
// state   | meaning
// TX_IDLE | no transfer; an accepted SBUF write loads tx_data
// TX_LOAD | tx_start pulse to the TX engine
// TX_BUSY | waiting for tx_done, then TI is raised
module uart_mode1_ctrl
  import uart_8051_pkg::*;
#(
  parameter logic [7:0] SCON_ADDR = SCON_ADDR_DEF,
  parameter logic [7:0] SBUF_ADDR = SBUF_ADDR_DEF,
  parameter int         DIV_SMOD0 = DIV_SMOD0_DEF,
  parameter int         DIV_SMOD1 = DIV_SMOD1_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_mode1_ctrl_if.slave sfr,
  input  logic             smod,
  input  logic             t1_ovf,
  output logic             tick_baud,
  output logic             rx_en,
  input  logic             rx_done,
  input  logic [7:0]       rx_data,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  input  logic             tx_done,
  output logic             irq
`ifdef UART_OVR_FLAG_EN
  ,
  output logic             ovr
`endif
);

  logic [7:0] scon;
  logic [7:0] scon_d;
  logic [7:0] rx_buf;
  logic       mode1;
  logic       wr_scon;
  logic       wr_sbuf;
  logic       rx_accept;
  logic       ti_set;
  logic       tx_load;

  tx_state_e  state_q;
  tx_state_e  state_d;

  assign mode1     = (uart_mode_e'(scon[SCON_SM0 -: 2]) == MODE1);
  assign rx_en     = mode1 & scon[SCON_REN];
  assign wr_scon   = sfr.sfr_wr && (sfr.sfr_addr == SCON_ADDR);
  assign wr_sbuf   = sfr.sfr_wr && (sfr.sfr_addr == SBUF_ADDR);
  assign rx_accept = rx_done && rx_en && !scon[SCON_RI];

  uart_baud_gen #(
    .DIV_SMOD0 (DIV_SMOD0),
    .DIV_SMOD1 (DIV_SMOD1)
  ) u_baud_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (mode1),
    .smod      (smod),
    .t1_ovf    (t1_ovf),
    .tick_baud (tick_baud)
  );

  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    tx_load  = 1'b0;
    ti_set   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (wr_sbuf && mode1 && !tx_busy) begin
          tx_load = 1'b1;
          state_d = TX_LOAD;
        end
      end
      TX_LOAD: begin
        tx_start = 1'b1;
        state_d  = TX_BUSY;
      end
      TX_BUSY: begin
        // Mode changes do not abort; only the engine's tx_done ends the transfer.
        if (tx_done) begin
          ti_set  = 1'b1;
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TX_IDLE;
    else        state_q <= state_d;
  end

  // Hardware flag sets override a coincident software write of the same bit.
  always_comb begin
    scon_d = scon;
    if (wr_scon) scon_d = sfr.sfr_wdata;
    if (rx_accept) begin
      scon_d[SCON_RI]  = 1'b1;
      scon_d[SCON_RB8] = 1'b1;
    end
    if (ti_set) scon_d[SCON_TI] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scon    <= '0;
      rx_buf  <= '0;
      tx_data <= '0;
      irq     <= 1'b0;
    end else begin
      scon <= scon_d;
      irq  <= scon[SCON_RI] | scon[SCON_TI];
      if (rx_accept) rx_buf  <= rx_data;
      if (tx_load)   tx_data <= sfr.sfr_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sfr.sfr_rdata <= '0;
    end else if (sfr.sfr_rd) begin
      if (sfr.sfr_addr == SCON_ADDR)      sfr.sfr_rdata <= scon;
      else if (sfr.sfr_addr == SBUF_ADDR) sfr.sfr_rdata <= rx_buf;
      else                                sfr.sfr_rdata <= 8'h00;
    end else begin
      sfr.sfr_rdata <= 8'h00;
    end
  end

`ifdef UART_OVR_FLAG_EN
  logic rx_drop;
  logic rd_sbuf;

  assign rx_drop = rx_done && rx_en && scon[SCON_RI];
  assign rd_sbuf = sfr.sfr_rd && (sfr.sfr_addr == SBUF_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovr <= 1'b0;
    else if (rx_drop) ovr <= 1'b1;
    else if (rd_sbuf) ovr <= 1'b0;
  end
`endif

endmodule
